// File: rtl/lsu_pkg.sv
// Shared LSU sizing and the memory-scheduler state encoding.
package lsu_pkg;

   localparam int unsigned LDQ_SIZE = 8;
   localparam int unsigned STQ_SIZE = 8;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } sched_state_e;

endpackage

// File: rtl/lsu_mem_scheduler_if.sv
// Queue-status and memory-port bundle between the LSU queues, the scheduler and data memory.
interface lsu_mem_scheduler_if #(
   parameter int unsigned LDQ_SIZE = lsu_pkg::LDQ_SIZE,
   parameter int unsigned STQ_SIZE = lsu_pkg::STQ_SIZE
);
   localparam int unsigned LDQ_W = $clog2(LDQ_SIZE);
   localparam int unsigned STQ_W = $clog2(STQ_SIZE);

   logic [LDQ_SIZE-1:0] ldq_ready;
   logic [LDQ_W-1:0]    ldq_head;
   logic [STQ_SIZE-1:0] stq_ready;
   logic [STQ_W-1:0]    stq_head;
   logic                stq_full;
   logic                flush;

   logic                mem_req_valid;
   logic                mem_req_ready;
   logic                mem_req_is_store;
   logic [LDQ_W-1:0]    mem_req_ldq_index;
   logic [STQ_W-1:0]    mem_req_stq_index;
   logic                mem_resp_valid;

   logic                load_executed;
   logic [LDQ_W-1:0]    ldq_mem_stage_index;
   logic                store_executed;
   logic [STQ_W-1:0]    store_executed_index;

   modport master (
      input  ldq_ready, ldq_head, stq_ready, stq_head, stq_full, flush,
      input  mem_req_ready, mem_resp_valid,
      output mem_req_valid, mem_req_is_store, mem_req_ldq_index, mem_req_stq_index,
      output load_executed, ldq_mem_stage_index, store_executed, store_executed_index
   );

   modport slave (
      output ldq_ready, ldq_head, stq_ready, stq_head, stq_full, flush,
      output mem_req_ready, mem_resp_valid,
      input  mem_req_valid, mem_req_is_store, mem_req_ldq_index, mem_req_stq_index,
      input  load_executed, ldq_mem_stage_index, store_executed, store_executed_index
   );

endinterface

// File: rtl/circular_priority_picker.sv
// Finds the first set ready bit walking forward from head, wrapping modulo SIZE.
module circular_priority_picker #(
   parameter int unsigned SIZE = 8
) (
   input  logic [SIZE-1:0]         ready,
   input  logic [$clog2(SIZE)-1:0] head,
   output logic                    valid,
   output logic [$clog2(SIZE)-1:0] index
);
   localparam int unsigned W = $clog2(SIZE);

   // Walk from the farthest offset down so the nearest-to-head hit is written last.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int k = SIZE - 1; k >= 0; k--) begin
         if (ready[head + W'(k)]) begin
            valid = 1'b1;
            index = head + W'(k);
         end
      end
   end

endmodule

// File: rtl/lsu_mem_scheduler.sv
// Arbitrates the oldest ready load against the committed STQ head onto the single data-memory
// port, tracking one outstanding access with store-starvation protection and flush handling.
module lsu_mem_scheduler #(
   parameter int unsigned LDQ_SIZE     = lsu_pkg::LDQ_SIZE,
   parameter int unsigned STQ_SIZE     = lsu_pkg::STQ_SIZE,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   lsu_mem_scheduler_if.master bus
);
   import lsu_pkg::*;

   localparam int unsigned LDQ_W = $clog2(LDQ_SIZE);
   localparam int unsigned STQ_W = $clog2(STQ_SIZE);
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   sched_state_e     state_q;
   logic             is_store_q;
   logic [LDQ_W-1:0] ldq_idx_q;
   logic [STQ_W-1:0] stq_idx_q;
   logic [CNT_W-1:0] starve_cnt_q;

   logic             ld_valid;
   logic [LDQ_W-1:0] ld_idx;
   logic             st_valid;
   logic             pick_store;
   logic             arb_go;
   logic             do_grant;

   circular_priority_picker #(
      .SIZE (LDQ_SIZE)
   ) u_ldq_picker (
      .ready (bus.ldq_ready),
      .head  (bus.ldq_head),
      .valid (ld_valid),
      .index (ld_idx)
   );

   always_comb begin
      st_valid   = bus.stq_ready[bus.stq_head];
      pick_store = st_valid &&
                   (!ld_valid || bus.stq_full || (starve_cnt_q == CNT_W'(STARVE_LIMIT)));
      arb_go     = (st_valid || ld_valid) && !bus.flush;
      do_grant   = arb_go && ((state_q == IDLE) || ((state_q == WAIT) && bus.mem_resp_valid));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         is_store_q   <= 1'b0;
         ldq_idx_q    <= '0;
         stq_idx_q    <= '0;
         starve_cnt_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (arb_go) state_q <= REQ;
            // A load may still be squashed by flush; a store here is already committed.
            REQ: begin
               if (!is_store_q && bus.flush) state_q <= IDLE;
               else if (bus.mem_req_ready)   state_q <= WAIT;
            end
            WAIT: if (bus.mem_resp_valid) state_q <= arb_go ? REQ : IDLE;
            default: state_q <= IDLE;
         endcase

         if (do_grant) begin
            is_store_q <= pick_store;
            if (pick_store) begin
               stq_idx_q    <= bus.stq_head;
               starve_cnt_q <= '0;
            end else begin
               ldq_idx_q <= ld_idx;
               if (st_valid && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
                  starve_cnt_q <= starve_cnt_q + 1'b1;
               end
            end
         end
      end
   end

   assign bus.mem_req_valid        = (state_q == REQ);
   assign bus.mem_req_is_store     = is_store_q;
   assign bus.mem_req_ldq_index    = ldq_idx_q;
   assign bus.mem_req_stq_index    = stq_idx_q;
   assign bus.load_executed        = (state_q == REQ) && !is_store_q && bus.mem_req_ready &&
                                     !bus.flush;
   assign bus.ldq_mem_stage_index  = ldq_idx_q;
   assign bus.store_executed       = (state_q == WAIT) && is_store_q && bus.mem_resp_valid;
   assign bus.store_executed_index = stq_idx_q;

endmodule

// File: tb/tb_lsu_mem_scheduler.sv
// Self-checking bench: vector table plus hand sequences, grants checked against a scoreboard.
module tb_lsu_mem_scheduler;
   import lsu_pkg::*;

   localparam int unsigned N = 8;

   typedef struct {
      logic       is_store;
      logic [2:0] idx;
   } exp_t;

   typedef struct {
      logic [7:0] ldq_ready;
      logic [2:0] ldq_head;
      logic [7:0] stq_ready;
      logic [2:0] stq_head;
      logic       stq_full;
      logic       exp_store;
      logic [2:0] exp_idx;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lsu_mem_scheduler_if #(.LDQ_SIZE(N), .STQ_SIZE(N)) bus ();

   lsu_mem_scheduler #(
      .LDQ_SIZE     (N),
      .STQ_SIZE     (N),
      .STARVE_LIMIT (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         last_acc = 0;
   int         prev_acc = 0;
   bit         resp_en = 1'b1;
   exp_t       exp_q[$];
   logic [2:0] st_done_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.ldq_ready = '0;
      bus.ldq_head  = '0;
      bus.stq_ready = '0;
      bus.stq_head  = '0;
      bus.stq_full  = 1'b0;
      bus.flush     = 1'b0;
   endtask

   task automatic wait_exp_size(input string name, input int target);
      int n = 0;
      while (exp_q.size() > target && n < 60) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), target);
      while (exp_q.size() > target) void'(exp_q.pop_front());
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!bus.mem_req_valid && n < 20) begin
         tick();
         n++;
      end
      check(name, bus.mem_req_valid, 1);
   endtask

   // Memory model: one-cycle response to every accepted request.
   initial begin
      logic acc;
      bus.mem_resp_valid = 1'b0;
      forever begin
         @(negedge clk);
         acc = rst_n && bus.mem_req_valid && bus.mem_req_ready &&
               (bus.mem_req_is_store || !bus.flush);
         @(posedge clk);
         cyc++;
         #1;
         if (resp_en) bus.mem_resp_valid = acc;
      end
   end

   // Scoreboard: every accepted request must match the head of exp_q.
   always @(negedge clk) begin : mon
      exp_t       x;
      logic [2:0] e;
      if (rst_n) begin
         check("exec_exclusive", bus.load_executed && bus.store_executed, 0);
         if (st_done_q.size() == 0) begin
            check("store_executed_idle", bus.store_executed, 0);
         end else if (bus.store_executed) begin
            e = st_done_q.pop_front();
            check("store_executed_index", bus.store_executed_index, e);
         end
         if (bus.mem_req_valid && bus.mem_req_ready && (bus.mem_req_is_store || !bus.flush)) begin
            prev_acc = last_acc;
            last_acc = cyc;
            check("grant_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               x = exp_q.pop_front();
               check("grant_is_store", bus.mem_req_is_store, x.is_store);
               if (x.is_store) begin
                  check("stq_index", bus.mem_req_stq_index, x.idx);
                  check("load_executed_on_store", bus.load_executed, 0);
                  st_done_q.push_back(x.idx);
               end else begin
                  check("ldq_index", bus.mem_req_ldq_index, x.idx);
                  check("load_executed", bus.load_executed, 1);
                  check("ldq_mem_stage_index", bus.ldq_mem_stage_index, x.idx);
               end
            end
         end else begin
            check("load_executed_idle", bus.load_executed, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[10];
      vt[0] = '{8'b0000_0101, 3'd6, 8'b0000_0000, 3'd0, 1'b0, 1'b0, 3'd0};
      vt[1] = '{8'b1000_0000, 3'd0, 8'b0000_0000, 3'd0, 1'b0, 1'b0, 3'd7};
      vt[2] = '{8'b0001_0000, 3'd4, 8'b0000_0000, 3'd0, 1'b0, 1'b0, 3'd4};
      vt[3] = '{8'b0000_1100, 3'd3, 8'b0000_0000, 3'd0, 1'b0, 1'b0, 3'd3};
      vt[4] = '{8'b0100_0010, 3'd7, 8'b0000_0000, 3'd0, 1'b0, 1'b0, 3'd1};
      vt[5] = '{8'b0000_0000, 3'd0, 8'b0000_1000, 3'd3, 1'b0, 1'b1, 3'd3};
      vt[6] = '{8'b0000_0001, 3'd0, 8'b1111_0111, 3'd3, 1'b0, 1'b0, 3'd0};
      vt[7] = '{8'b0010_0000, 3'd0, 8'b0000_0001, 3'd0, 1'b1, 1'b1, 3'd0};
      vt[8] = '{8'b0000_0010, 3'd0, 8'b0010_0000, 3'd5, 1'b0, 1'b0, 3'd1};
      vt[9] = '{8'b0000_0000, 3'd0, 8'b0100_0000, 3'd6, 1'b0, 1'b1, 3'd6};

      idle_inputs();
      bus.mem_req_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_req_valid", bus.mem_req_valid, 0);
      check("rst_load_executed", bus.load_executed, 0);
      check("rst_store_executed", bus.store_executed, 0);
      check("rst_state", dut.state_q, IDLE);
      check("rst_starve_cnt", dut.starve_cnt_q, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         bus.ldq_ready = vt[i].ldq_ready;
         bus.ldq_head  = vt[i].ldq_head;
         bus.stq_ready = vt[i].stq_ready;
         bus.stq_head  = vt[i].stq_head;
         bus.stq_full  = vt[i].stq_full;
         exp_q.push_back('{vt[i].exp_store, vt[i].exp_idx});
         wait_exp_size($sformatf("vec%0d_drain", i), 0);
         idle_inputs();
         repeat (3) tick();
      end

      // Wrap-around search with back-to-back issue.
      bus.ldq_head  = 3'd6;
      bus.ldq_ready = 8'b0000_0101;
      exp_q.push_back('{1'b0, 3'd0});
      exp_q.push_back('{1'b0, 3'd2});
      wait_exp_size("wrap_first", 1);
      bus.ldq_ready = 8'b0000_0100;
      wait_exp_size("wrap_second", 0);
      check("b2b_spacing", last_acc - prev_acc, 2);
      idle_inputs();
      repeat (3) tick();

      // Starvation: four loads, then the waiting store.
      bus.ldq_ready = 8'hFF;
      bus.stq_ready = 8'b0000_0001;
      for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 3'd0});
      exp_q.push_back('{1'b1, 3'd0});
      wait_exp_size("starve_drain", 0);
      idle_inputs();
      repeat (3) tick();
      check("starve_cnt_cleared", dut.starve_cnt_q, 0);

      // Flush in IDLE blocks arbitration for that cycle only.
      bus.ldq_ready = 8'b0000_1000;
      bus.flush     = 1'b1;
      tick();
      check("flush_idle_blocks", bus.mem_req_valid, 0);
      bus.flush = 1'b0;
      exp_q.push_back('{1'b0, 3'd3});
      wait_exp_size("flush_idle_drain", 0);
      idle_inputs();
      repeat (3) tick();

      // Flush on accept of a load: request dropped, no pulse.
      bus.mem_req_ready = 1'b0;
      bus.ldq_ready     = 8'b0000_0010;
      wait_req("flush_load_req");
      bus.flush         = 1'b1;
      bus.mem_req_ready = 1'b1;
      bus.ldq_ready     = '0;
      tick();
      check("flush_load_valid", bus.mem_req_valid, 0);
      check("flush_load_state", dut.state_q, IDLE);
      bus.flush = 1'b0;
      repeat (2) tick();

      // Same with a store: it proceeds.
      bus.mem_req_ready = 1'b0;
      bus.stq_head      = 3'd2;
      bus.stq_ready     = 8'b0000_0100;
      wait_req("flush_store_req");
      exp_q.push_back('{1'b1, 3'd2});
      bus.flush         = 1'b1;
      bus.mem_req_ready = 1'b1;
      bus.stq_ready     = '0;
      tick();
      check("flush_store_state", dut.state_q, WAIT);
      bus.flush = 1'b0;
      wait_exp_size("flush_store_drain", 0);
      repeat (3) tick();
      check("flush_store_done", st_done_q.size(), 0);
      idle_inputs();

      // Reset during WAIT of a store; a late response must not pulse.
      resp_en            = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.stq_head       = 3'd4;
      bus.stq_ready      = 8'b0001_0000;
      exp_q.push_back('{1'b1, 3'd4});
      wait_exp_size("rst_mid_drain", 0);
      idle_inputs();
      check("rst_mid_in_wait", dut.state_q, WAIT);
      rst_n = 1'b0;
      #1;
      check("rst_mid_req_valid", bus.mem_req_valid, 0);
      check("rst_mid_is_store", bus.mem_req_is_store, 0);
      check("rst_mid_stq_index", bus.mem_req_stq_index, 0);
      check("rst_mid_ldq_index", bus.mem_req_ldq_index, 0);
      check("rst_mid_load_exec", bus.load_executed, 0);
      check("rst_mid_store_exec", bus.store_executed, 0);
      check("rst_mid_store_idx", bus.store_executed_index, 0);
      check("rst_mid_stage_idx", bus.ldq_mem_stage_index, 0);
      check("rst_mid_state", dut.state_q, IDLE);
      st_done_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      bus.mem_resp_valid = 1'b1;
      tick();
      bus.mem_resp_valid = 1'b0;
      resp_en = 1'b1;
      tick();
      check("rst_late_resp_state", dut.state_q, IDLE);
      check("rst_late_resp_valid", bus.mem_req_valid, 0);

      check("store_done_pending", st_done_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
